// File: rtl/d_mux4_pkg.sv
// Shared types and constants for the 4-channel demux dispatcher.
package d_mux4_pkg;
  localparam int NumCh    = 4;
  localparam int ClearLen = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } dispatch_state_e;

  function automatic ch_sel_t rr_next(input ch_sel_t cur);
    if (cur == ch_sel_t'(NumCh - 1)) begin
      rr_next = 2'd0;
    end else begin
      rr_next = cur + 2'd1;
    end
  endfunction
endpackage

// File: rtl/d_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; simultaneous push and pop allowed.
module d_sync_fifo #(
  parameter int Width = 18,
  parameter int Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0] PtrOne  = (AddrW + 1)'(1);

  logic [AddrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic [Width-1:0]   mem_d [Depth];
  logic               do_push_s, do_pop_s;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (count_o == FullCnt);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PtrOne;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/d_mux4_dispatch.sv
// Feeds the 4-way registered demux: buffers a word stream and issues one
// {sel, value} pair per cycle, addressed or round-robin, plus a zero sweep.
module d_mux4_dispatch
  import d_mux4_pkg::*;
#(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [Width-1:0]       in_data_i,
  input  logic [1:0]             in_dest_i,
  input  logic                   rr_mode_i,
  input  logic                   clear_i,
  output logic [1:0]             sel_o,
  output logic [Width-1:0]       value_o,
  output logic                   issue_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   busy_o
);
  localparam int CntW = $clog2(Depth) + 1;
  localparam int EntW = Width + 2;

  dispatch_state_e  state_q, state_d;
  ch_sel_t          rr_q, rr_d, sweep_q, sweep_d, sel_q, sel_d;
  logic [Width-1:0] value_q, value_d;
  logic             issue_q, issue_d;
  logic             push_s, pop_s, full_s, empty_s, clear_start_s;
  logic [CntW-1:0]  count_s, count_nxt_s;
  logic [EntW-1:0]  head_s;

  d_sync_fifo #(.Width(EntW), .Depth(Depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .data_i  ({in_dest_i, in_data_i}),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // A clear request wins over a pop in the same cycle; queued words wait out the sweep.
  assign in_ready_o    = ~rst_i & ~full_s;
  assign push_s        = in_valid_i & in_ready_o;
  assign clear_start_s = clear_i & (state_q != S_CLEAR);
  assign pop_s         = (state_q == S_RUN) & ~clear_i & ~empty_s;
  assign count_nxt_s   = count_s + {{(CntW-1){1'b0}}, push_s} - {{(CntW-1){1'b0}}, pop_s};

  assign sel_o   = sel_q;
  assign value_o = value_q;
  assign issue_o = issue_q;
  assign count_o = count_s;
  assign busy_o  = (state_q == S_CLEAR) | (count_s != {CntW{1'b0}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (clear_i) begin
          state_d = S_CLEAR;
        end else if (count_nxt_s != {CntW{1'b0}}) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (sweep_q != ch_sel_t'(ClearLen - 1)) begin
          state_d = S_CLEAR;
        end else if (count_nxt_s != {CntW{1'b0}}) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    value_d = value_q;
    issue_d = 1'b0;
    rr_d    = rr_q;
    sweep_d = sweep_q;
    if (clear_start_s) begin
      rr_d    = 2'd0;
      sweep_d = 2'd0;
    end else if (state_q == S_CLEAR) begin
      sel_d   = sweep_q;
      value_d = {Width{1'b0}};
      issue_d = 1'b1;
      sweep_d = sweep_q + 2'd1;
    end else if (pop_s) begin
      value_d = head_s[Width-1:0];
      issue_d = 1'b1;
      if (rr_mode_i) begin
        sel_d = rr_q;
        rr_d  = rr_next(rr_q);
      end else begin
        sel_d = head_s[EntW-1 -: 2];
      end
    end else begin
      issue_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= 2'd0;
      value_q <= {Width{1'b0}};
      issue_q <= 1'b0;
      rr_q    <= 2'd0;
      sweep_q <= 2'd0;
    end else begin
      sel_q   <= sel_d;
      value_q <= value_d;
      issue_q <= issue_d;
      rr_q    <= rr_d;
      sweep_q <= sweep_d;
    end
  end
endmodule

// File: tb/tb_d_mux4_dispatch.sv
// Self-checking bench for d_mux4_dispatch: vector table plus hand-written
// sequences, with a scoreboard queue of expected {sel, value} issues.
module tb_d_mux4_dispatch;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic [1:0]  in_dest_i;
  logic        rr_mode_i;
  logic        clear_i;
  logic [1:0]  sel_o;
  logic [15:0] value_o;
  logic        issue_o;
  logic [2:0]  count_o;
  logic        busy_o;

  d_mux4_dispatch #(.Width(16), .Depth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_dest_i(in_dest_i), .rr_mode_i(rr_mode_i),
    .clear_i(clear_i), .sel_o(sel_o), .value_o(value_o), .issue_o(issue_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] value;
  } exp_t;

  typedef struct {
    logic [1:0]  dest;
    logic [15:0] data;
    logic        rr;
    logic [1:0]  exp_sel;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_waits = 0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every issue must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (issue_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue actual sel %0d value %0h required no issue", sel_o, value_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_sel", {30'd0, sel_o}, {30'd0, mon_e.sel});
        chk("issue_value", {16'd0, value_o}, {16'd0, mon_e.value});
      end
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [15:0] v, input logic [1:0] esel,
                      input bit expect_it);
    int  waits;
    logic acc;
    waits = 0;
    acc = 1'b0;
    in_valid_i = 1'b1;
    in_dest_i  = d;
    in_data_i  = v;
    while (!acc && waits < 50) begin
      acc = in_ready_o;
      step();
      if (!acc) waits++;
    end
    if (acc) begin
      if (expect_it) exp_q.push_back({esel, v});
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout actual not accepted required accepted data %0h", v);
    end
    last_waits = waits;
  endtask

  task automatic push_sweep(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k[1:0], 16'h0000});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    step();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    clear_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual still running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{dest: 2'd2, data: 16'hBEEF, rr: 1'b0, exp_sel: 2'd2};
    tbl[1] = '{dest: 2'd1, data: 16'h1111, rr: 1'b1, exp_sel: 2'd0};
    tbl[2] = '{dest: 2'd3, data: 16'h2222, rr: 1'b1, exp_sel: 2'd1};
    tbl[3] = '{dest: 2'd0, data: 16'h3333, rr: 1'b0, exp_sel: 2'd0};
    tbl[4] = '{dest: 2'd3, data: 16'h4444, rr: 1'b1, exp_sel: 2'd2};
    tbl[5] = '{dest: 2'd0, data: 16'h5555, rr: 1'b1, exp_sel: 2'd3};
    tbl[6] = '{dest: 2'd1, data: 16'h6666, rr: 1'b1, exp_sel: 2'd0};
    tbl[7] = '{dest: 2'd3, data: 16'h7777, rr: 1'b0, exp_sel: 2'd3};

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    in_data_i = 16'h0000;
    in_dest_i = 2'd0;
    rr_mode_i = 1'b0;
    clear_i = 1'b0;
    step();
    step();
    chk("rst_sel", {30'd0, sel_o}, 32'd0);
    chk("rst_value", {16'd0, value_o}, 32'd0);
    chk("rst_issue", {31'd0, issue_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ready_low", {31'd0, in_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready_o}, 32'd1);
    step();

    // Single words: one-cycle latency, pointer advances only in rr mode.
    for (int i = 0; i < 8; i++) begin
      rr_mode_i = tbl[i].rr;
      send(tbl[i].dest, tbl[i].data, tbl[i].exp_sel, 1'b1);
      in_valid_i = 1'b0;
      chk("tbl_count_after_push", {29'd0, count_o}, 32'd1);
      chk("tbl_no_issue_yet", {31'd0, issue_o}, 32'd0);
      chk("tbl_busy", {31'd0, busy_o}, 32'd1);
      step();
      chk("tbl_issue", {31'd0, issue_o}, 32'd1);
      chk("tbl_sel", {30'd0, sel_o}, {30'd0, tbl[i].exp_sel});
      chk("tbl_value", {16'd0, value_o}, {16'd0, tbl[i].data});
      chk("tbl_count_after_pop", {29'd0, count_o}, 32'd0);
      step();
      chk("tbl_issue_one_cycle", {31'd0, issue_o}, 32'd0);
    end
    drain();

    // Clear with two words arriving; rr pointer (now 1) restarts at 0.
    rr_mode_i = 1'b1;
    push_sweep(4);
    clear_i = 1'b1;
    send(2'd1, 16'hD001, 2'd0, 1'b1);
    clear_i = 1'b0;
    send(2'd2, 16'hD002, 2'd1, 1'b1);
    in_valid_i = 1'b0;
    step();
    step();
    step();
    chk("clr_last_sel", {30'd0, sel_o}, 32'd3);
    chk("clr_last_value", {16'd0, value_o}, 32'd0);
    chk("clr_count_held", {29'd0, count_o}, 32'd2);
    chk("clr_busy", {31'd0, busy_o}, 32'd1);
    step();
    chk("clr_first_word_sel", {30'd0, sel_o}, 32'd0);
    chk("clr_first_word_val", {16'd0, value_o}, 32'h0000D001);
    chk("clr_first_word_cnt", {29'd0, count_o}, 32'd1);
    drain();

    // Six back-to-back round-robin words.
    reset_dut();
    rr_mode_i = 1'b1;
    max_run = 0;
    for (int i = 1; i <= 6; i++) begin
      send(2'(i), 16'(i), 2'((i - 1) % 4), 1'b1);
      chk("stream_ready_high", last_waits, 32'd0);
    end
    in_valid_i = 1'b0;
    drain();
    chk("stream_issue_run", max_run, 32'd6);

    // Five pushes while a sweep blocks pops; the fifth waits for space.
    rr_mode_i = 1'b0;
    push_sweep(4);
    clear_i = 1'b1;
    send(2'd0, 16'hA001, 2'd0, 1'b1);
    clear_i = 1'b0;
    send(2'd1, 16'hA002, 2'd1, 1'b1);
    send(2'd2, 16'hA003, 2'd2, 1'b1);
    send(2'd3, 16'hA004, 2'd3, 1'b1);
    chk("full_ready_low", {31'd0, in_ready_o}, 32'd0);
    chk("full_count", {29'd0, count_o}, 32'd4);
    send(2'd1, 16'hA005, 2'd1, 1'b1);
    in_valid_i = 1'b0;
    chk("fifth_held_cycles", last_waits, 32'd2);
    drain();
    chk("full_drained_count", {29'd0, count_o}, 32'd0);

    // Mode switch to rr while dest=3 words are queued.
    reset_dut();
    rr_mode_i = 1'b0;
    push_sweep(4);
    clear_i = 1'b1;
    send(2'd3, 16'hC001, 2'd3, 1'b1);
    clear_i = 1'b0;
    send(2'd3, 16'hC002, 2'd0, 1'b1);
    send(2'd3, 16'hC003, 2'd1, 1'b1);
    in_valid_i = 1'b0;
    step();
    step();
    step();
    rr_mode_i = 1'b1;
    drain();

    // Reset during the third sweep cycle with three words queued.
    rr_mode_i = 1'b0;
    push_sweep(3);
    clear_i = 1'b1;
    send(2'd1, 16'hB001, 2'd1, 1'b0);
    clear_i = 1'b0;
    send(2'd2, 16'hB002, 2'd2, 1'b0);
    send(2'd3, 16'hB003, 2'd3, 1'b0);
    in_valid_i = 1'b0;
    step();
    chk("mid_sweep_sel", {30'd0, sel_o}, 32'd2);
    chk("mid_sweep_count", {29'd0, count_o}, 32'd3);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready_low", {31'd0, in_ready_o}, 32'd0);
    step();
    chk("mid_rst_count", {29'd0, count_o}, 32'd0);
    chk("mid_rst_sel", {30'd0, sel_o}, 32'd0);
    chk("mid_rst_value", {16'd0, value_o}, 32'd0);
    chk("mid_rst_issue", {31'd0, issue_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_rst_no_leftover", exp_q.size(), 32'd0);
    chk("mid_rst_still_empty", {29'd0, count_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
